// File: rtl/sysid_pkg.sv
// sysid_pkg: shared SysID signature constants, probe FSM encoding and register-file size.
package sysid_pkg;
    localparam logic [15:0] SYSID_VENDOR  = 16'hEA68;
    localparam logic [15:0] SYSID_VERSION = 16'h0001;
    localparam logic [31:0] SYSID_WORD0   = {SYSID_VENDOR, SYSID_VERSION};
    localparam logic [31:0] SYSID_WORD1   = 32'h0000_0000;
    localparam logic [31:0] SYSID_WORD2   = 32'hA5A5_A5A5;
    localparam logic [31:0] SYSID_WORD3   = 32'h5A5A_5A5A;
    localparam int NUM_WORDS = 4;
    localparam int ADDR_W    = $clog2(NUM_WORDS);

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_CHECK, ST_DONE} probe_state_t;

    function automatic logic [31:0] sysid_word(input int unsigned idx);
        return idx == 0 ? SYSID_WORD0 : idx == 1 ? SYSID_WORD1 : idx == 2 ? SYSID_WORD2 : SYSID_WORD3;
    endfunction
endpackage

// File: rtl/sysid_probe_master_if.sv
// sysid_probe_master_if: Avalon-MM read-only link between the probe master and the SysID slave.
interface sysid_probe_master_if;
    import sysid_pkg::*;
    logic [ADDR_W-1:0] address;
    logic              read;
    logic [31:0]       readdata;
    logic              waitrequest;

    modport master (output address, read, input readdata, waitrequest);
    modport slave  (input address, read, output readdata, waitrequest);
endinterface

// File: rtl/sysid_probe_timer.sv
// sysid_probe_timer: counts consecutive stalled cycles; expire fires on the LIMIT-th one.
module sysid_probe_timer #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = $clog2(LIMIT);

    logic [CW-1:0] count;

    assign expire = en && (count == CW'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr || expire)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/sysid_probe_master.sv
// sysid_probe_master: Avalon-MM master that reads the four SysID words, checks the signature and
// reports vendor/version/status. Define SYSID_PROBE_RETRY_EN to retry failed probes up to RETRY_MAX times.
module sysid_probe_master
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXP_WORD0      = SYSID_WORD0,
    parameter logic [31:0] EXP_WORD1      = SYSID_WORD1,
    parameter logic [31:0] EXP_WORD2      = SYSID_WORD2,
    parameter logic [31:0] EXP_WORD3      = SYSID_WORD3,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned RETRY_MAX      = 3
) (
    input  logic                 csi_MCLK_clk,
    input  logic                 rsi_MRST_reset,
    sysid_probe_master_if.master avm_Probe,
    input  logic                 coe_Probe_start,
    output logic                 coe_Probe_busy,
    output logic                 coe_Probe_done,
    output logic                 coe_Probe_ok,
    output logic                 coe_Probe_timeout,
    output logic [15:0]          coe_Probe_vendor,
    output logic [15:0]          coe_Probe_version
);
    probe_state_t      state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       words [NUM_WORDS];
    logic              ok_q, timeout_q;
    logic              stall, accept, last, expire, match, can_retry, restart;

    assign stall   = (state == ST_READ) && avm_Probe.waitrequest;
    assign accept  = (state == ST_READ) && !avm_Probe.waitrequest;
    assign last    = addr == ADDR_W'(NUM_WORDS - 1);
    assign restart = (state == ST_DONE) && coe_Probe_start;
    assign match   = (words[0] == EXP_WORD0) && (words[1] == EXP_WORD1) &&
                     (words[2] == EXP_WORD2) && (words[3] == EXP_WORD3);

    sysid_probe_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clk    (csi_MCLK_clk),
        .rst_n  (rsi_MRST_reset),
        .clr    (!stall),
        .en     (stall),
        .expire (expire)
    );

`ifdef SYSID_PROBE_RETRY_EN
    localparam int RW = RETRY_MAX > 0 ? $clog2(RETRY_MAX + 1) : 1;

    logic [RW-1:0] retries;

    assign can_retry = retries < RW'(RETRY_MAX);

    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset) begin
        if (!rsi_MRST_reset)
            retries <= '0;
        else if (restart)
            retries <= '0;
        else if (can_retry && (expire || ((state == ST_CHECK) && !match)))
            retries <= retries + 1'b1;
    end
`else
    // Single attempt; RETRY_MAX only matters when retries are compiled in.
    assign can_retry = 1'b0 && (RETRY_MAX != 0);
`endif

    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset) begin
        if (!rsi_MRST_reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = ST_READ;
            ST_READ:  state_nxt = expire ? (can_retry ? ST_READ : ST_DONE) : (accept && last) ? ST_CHECK : ST_READ;
            ST_CHECK: state_nxt = (match || !can_retry) ? ST_DONE : ST_READ;
            ST_DONE:  state_nxt = coe_Probe_start ? ST_READ : ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        avm_Probe.read = state == ST_READ;
        coe_Probe_busy = (state == ST_READ) || (state == ST_CHECK);
        coe_Probe_done = state == ST_DONE;
    end

    // Words not reached by an aborted probe keep whatever the previous probe captured.
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset) begin
        if (!rsi_MRST_reset) begin
            addr      <= '0;
            words     <= '{default: '0};
            ok_q      <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (accept) begin
                words[addr] <= avm_Probe.readdata;
                if (!last)
                    addr <= addr + 1'b1;
            end
            if (expire) begin
                addr      <= '0;
                ok_q      <= 1'b0;
                timeout_q <= !can_retry;
            end
            if (state == ST_CHECK) begin
                addr <= '0;
                ok_q <= match;
            end
            if (restart) begin
                addr      <= '0;
                ok_q      <= 1'b0;
                timeout_q <= 1'b0;
            end
        end
    end

    assign avm_Probe.address = addr;
    assign coe_Probe_ok      = ok_q;
    assign coe_Probe_timeout = timeout_q;
    assign coe_Probe_vendor  = words[0][31:16];
    assign coe_Probe_version = words[0][15:0];
endmodule

// File: tb/tb_sysid_probe_master.sv
// tb_sysid_probe_master: directed and randomized probes against a scripted SysID slave and a
// word-level model of the expected probe outcome.
module tb_sysid_probe_master;
    import sysid_pkg::*;

    localparam int TMO = 64;
`ifdef SYSID_PROBE_RETRY_EN
    localparam int MAX_ATT = 4;
`else
    localparam int MAX_ATT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, ok, timeout;
    logic [15:0] vendor, version;

    sysid_probe_master_if bus();

    sysid_probe_master #(.TIMEOUT_CYCLES(TMO), .RETRY_MAX(3)) dut (
        .csi_MCLK_clk      (clk),
        .rsi_MRST_reset    (rst_n),
        .avm_Probe         (bus.master),
        .coe_Probe_start   (start),
        .coe_Probe_busy    (busy),
        .coe_Probe_done    (done),
        .coe_Probe_ok      (ok),
        .coe_Probe_timeout (timeout),
        .coe_Probe_vendor  (vendor),
        .coe_Probe_version (version)
    );

    always #5 clk = ~clk;

    // Scripted slave: stalls a chosen address for stall_len cycles (or forever when stuck),
    // and can corrupt word 2 for its first few reads.
    logic [31:0] mem [4];
    int          stall_addr = -1;
    int          stall_len = 0;
    bit          stuck = 1'b0;
    int          corrupt_until = 0;
    int          scnt = 0;
    int          w2s = 0;

    assign bus.waitrequest = bus.read && (int'(bus.address) == stall_addr) && (stuck || scnt < stall_len);
    assign bus.readdata    = mem[bus.address] ^ ((bus.address == 2'd2 && w2s < corrupt_until) ? 32'd1 : 32'd0);

    always @(posedge clk) begin
        scnt <= (bus.read && bus.waitrequest) ? scnt + 1 : 0;
        if (bus.read && !bus.waitrequest && bus.address == 2'd2)
            w2s <= w2s + 1;
    end

    logic [1:0] acc_log [$];
    int         stall_total = 0;

    always @(negedge clk) begin
        if (bus.read === 1'b1) begin
            if (!bus.waitrequest)
                acc_log.push_back(bus.address);
            else
                stall_total++;
        end
    end

    int          checks = 0;
    int          failures = 0;
    logic [31:0] mw [4];
    bit          exp_ok, exp_to;
    logic [1:0]  exp_seq [$];
    int          exp_stalls;
    int          base_i, st0_i;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Walk each attempt word by word: a stuck address ends the attempt, otherwise the signature decides.
    task automatic model_probe();
        int w2m = w2s;
        bit pass = 1'b0;
        bit to = 1'b0;
        exp_seq.delete();
        exp_stalls = 0;
        for (int a = 0; a < MAX_ATT && !pass; a++) begin
            to = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (stuck && i == stall_addr) begin
                    exp_stalls += TMO;
                    to = 1'b1;
                    break;
                end
                if (i == stall_addr)
                    exp_stalls += stall_len;
                mw[i] = mem[i] ^ ((i == 2 && w2m < corrupt_until) ? 32'd1 : 32'd0);
                if (i == 2)
                    w2m++;
                exp_seq.push_back(2'(i));
            end
            pass = !to;
            for (int i = 0; i < 4; i++)
                if (mw[i] != sysid_word(i))
                    pass = 1'b0;
        end
        exp_ok = pass;
        exp_to = to;
        base_i = acc_log.size();
        st0_i  = stall_total;
    endtask

    task automatic finish_probe(input string tag);
        int          n = 0;
        int          cnt;
        logic [63:0] enc_got = '0;
        logic [63:0] enc_exp = '0;
        while (done !== 1'b1 && n < 3000) begin
            cyc();
            n++;
        end
        chk({tag, ":wait_done"}, 64'(n < 3000), 64'(1));
        repeat (3) cyc();
        chk({tag, ":done_hold"}, 64'(done), 64'(1));
        chk({tag, ":busy"}, 64'(busy), 64'(0));
        chk({tag, ":ok"}, 64'(ok), 64'(exp_ok));
        chk({tag, ":timeout"}, 64'(timeout), 64'(exp_to));
        chk({tag, ":vendor"}, 64'(vendor), 64'(mw[0][31:16]));
        chk({tag, ":version"}, 64'(version), 64'(mw[0][15:0]));
        cnt = acc_log.size() - base_i;
        chk({tag, ":n_reads"}, 64'(cnt), 64'(exp_seq.size()));
        for (int i = 0; i < cnt && i < 32; i++)
            enc_got = (enc_got << 2) | 64'(acc_log[base_i + i]);
        for (int i = 0; i < exp_seq.size() && i < 32; i++)
            enc_exp = (enc_exp << 2) | 64'(exp_seq[i]);
        chk({tag, ":addr_seq"}, enc_got, enc_exp);
        chk({tag, ":stalls"}, 64'(stall_total - st0_i), 64'(exp_stalls));
    endtask

    task automatic start_probe(input string tag, input bit poke);
        model_probe();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk({tag, ":cleared"}, 64'({done, ok, timeout}), 64'(0));
        chk({tag, ":busy_on"}, 64'(busy), 64'(1));
        if (poke) begin
            cyc();
            start = 1'b1;
            cyc();
            start = 1'b0;
        end
        finish_probe(tag);
    endtask

    task automatic clean_slave();
        for (int i = 0; i < 4; i++)
            mem[i] = sysid_word(i);
        stall_addr = -1;
        stall_len  = 0;
        stuck      = 1'b0;
    endtask

    initial begin
        clean_slave();
        for (int i = 0; i < 4; i++)
            mw[i] = '0;
        repeat (3) cyc();
        chk("rst:busy", 64'(busy), 64'(0));
        chk("rst:done", 64'(done), 64'(0));
        chk("rst:ok", 64'(ok), 64'(0));
        chk("rst:timeout", 64'(timeout), 64'(0));
        chk("rst:vendor", 64'(vendor), 64'(0));
        chk("rst:version", 64'(version), 64'(0));
        chk("rst:read", 64'(bus.read), 64'(0));
        chk("rst:address", 64'(bus.address), 64'(0));

        model_probe();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("t1:addr%0d", i), 64'(bus.address), 64'(i));
            chk($sformatf("t1:read%0d", i), 64'(bus.read), 64'(1));
        end
        cyc();
        chk("t1:check_read", 64'(bus.read), 64'(0));
        chk("t1:check_done", 64'(done), 64'(0));
        cyc();
        chk("t1:done_at_5", 64'(done), 64'(1));
        finish_probe("t1");

        mem[2] = 32'hA5A5_A5A4;
        start_probe("t2_bad_w2", 1'b0);

        clean_slave();
        stall_addr = 1;
        stall_len  = 3;
        start_probe("t3_stall_poke", 1'b1);

        stall_addr = 2;
        stuck      = 1'b1;
        start_probe("t4_stuck", 1'b0);

        clean_slave();
        start_probe("t5_recover", 1'b0);

`ifdef SYSID_PROBE_RETRY_EN
        corrupt_until = w2s + 2;
        start_probe("r1_two_bad", 1'b0);
        mem[3] = 32'h5A5A_5A5B;
        start_probe("r2_all_bad", 1'b0);
        clean_slave();
`endif

        for (int k = 0; k < 12; k++) begin
            int kind = int'($urandom_range(0, 3));
            clean_slave();
            if (kind == 1) begin
                int w = int'($urandom_range(0, 3));
                mem[w] = mem[w] ^ ($urandom | 32'h1);
            end
            if (kind >= 2) begin
                stall_addr = int'($urandom_range(0, 3));
                stall_len  = int'($urandom_range(1, 5));
            end
            stuck = kind == 3;
            start_probe($sformatf("rnd%0d_k%0d", k, kind), 1'b0);
        end

        clean_slave();
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst:read", 64'(bus.read), 64'(0));
        chk("mid_rst:busy", 64'(busy), 64'(0));
        chk("mid_rst:vendor", 64'(vendor), 64'(0));
        cyc();
        for (int i = 0; i < 4; i++)
            mw[i] = '0;
        model_probe();
        rst_n = 1'b1;
        finish_probe("mid_rst_rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
